maze_navigate: RTL and testbench

//  Responder side of the solver<->navigator move handshake. Accepts strt_hdng / strt_mv strobes

---
 rtl/maze_navigate.sv | 123 ++++++++++++
 tb/tb_maze_navigate.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_navigate.sv
// Navigator side of the solver/navigator move handshake. It handles heading changes,
// ramps the forward speed for straight moves, and sends a one-cycle mv_cmplt pulse
// when each move finishes.
module maze_navigate #(
  parameter logic        FAST_SIM = 1'b1,
  parameter logic [10:0] MAX_SPD  = 11'h2A0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        at_hdng,
  input  logic        frwrd_opn,
  input  logic        lft_opn,
  input  logic        rght_opn,
  output logic        mv_cmplt,
  output logic        moving,
  output logic        en_fusion,
  output logic [10:0] frwrd_spd
);

  localparam logic [10:0] FRWRD_INC = FAST_SIM ? 11'h018 : 11'h002;
  localparam logic [11:0] FAST_DEC  = {1'b0, FRWRD_INC} << 2;

  typedef enum logic [2:0] {IDLE, HDNG, ACCEL, DECEL, DECEL_FAST} state_t;

  state_t      state, state_nxt;
  logic [10:0] spd_nxt;
  logic        cmplt_nxt;
  logic        lft_opn_ff, rght_opn_ff;
  logic        lft_rise, rght_rise, side_stop;
  logic [11:0] inc_sum, dec_diff, fast_diff;
  logic [10:0] inc_sat, dec_sat, fast_sat;

  // Rising edges of the side openings. The reset value of 1 keeps an opening that is
  // already present at reset from looking like a new edge.
  assign lft_rise  = lft_opn & ~lft_opn_ff;
  assign rght_rise = rght_opn & ~rght_opn_ff;
  assign side_stop = (stp_lft & lft_rise) | (stp_rght & rght_rise);

  // The 12-bit intermediates expose overflow past the ceiling and underflow below zero.
  assign inc_sum   = {1'b0, frwrd_spd} + {1'b0, FRWRD_INC};
  assign dec_diff  = {1'b0, frwrd_spd} - {1'b0, FRWRD_INC};
  assign fast_diff = {1'b0, frwrd_spd} - FAST_DEC;
  assign inc_sat   = (inc_sum > {1'b0, MAX_SPD}) ? MAX_SPD : inc_sum[10:0];
  assign dec_sat   = dec_diff[11]  ? 11'h000 : dec_diff[10:0];
  assign fast_sat  = fast_diff[11] ? 11'h000 : fast_diff[10:0];

  assign en_fusion = frwrd_spd > (MAX_SPD >> 1);

  // Registers for the state, the speed, the completion pulse and the side-opening history.
  // NOTE: non-blocking assignments let every register here sample the values from before
  // the clock edge, so the order of the statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frwrd_spd   <= 11'h000;
      mv_cmplt    <= 1'b0;
      lft_opn_ff  <= 1'b1;
      rght_opn_ff <= 1'b1;
    end else begin
      state       <= state_nxt;
      frwrd_spd   <= spd_nxt;
      mv_cmplt    <= cmplt_nxt;
      lft_opn_ff  <= lft_opn;
      rght_opn_ff <= rght_opn;
    end
  end

  // Next-state decode, speed update and the moving flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one of
    // them unassigned and no latch is inferred.
    state_nxt = state;
    spd_nxt   = frwrd_spd;
    cmplt_nxt = 1'b0;
    moving    = 1'b1;
    unique case (state)
      IDLE: begin
        moving  = 1'b0;
        spd_nxt = 11'h000;
        if (strt_hdng)    state_nxt = HDNG;
        else if (strt_mv) state_nxt = ACCEL;
      end
      HDNG: begin
        spd_nxt = 11'h000;
        if (at_hdng) begin
          state_nxt = IDLE;
          cmplt_nxt = 1'b1;
        end
      end
      ACCEL: begin
        spd_nxt = inc_sat;
        if (!frwrd_opn)     state_nxt = DECEL_FAST;
        else if (side_stop) state_nxt = DECEL;
      end
      DECEL: begin
        if (frwrd_spd == 11'h000) begin
          state_nxt = IDLE;
          cmplt_nxt = 1'b1;
        end else begin
          spd_nxt = dec_sat;
          if (!frwrd_opn) state_nxt = DECEL_FAST;
        end
      end
      DECEL_FAST: begin
        if (frwrd_spd == 11'h000) begin
          state_nxt = IDLE;
          cmplt_nxt = 1'b1;
        end else begin
          spd_nxt = fast_sat;
        end
      end
      default: begin
        state_nxt = IDLE;
        spd_nxt   = 11'h000;
      end
    endcase
  end

endmodule

// File: tb/tb_maze_navigate.sv
// Self-checking bench for maze_navigate. Expected speeds are pushed to a scoreboard
// queue when stimulus is driven, then popped and compared one per clock.
module tb_maze_navigate;

  localparam logic [10:0] MAX = 11'h2A0;
  localparam logic [10:0] INC = 11'h018;
  localparam logic [10:0] HALF = MAX >> 1;

  logic        clk = 1'b0;
  logic        rst, strt_hdng, strt_mv, stp_lft, stp_rght, at_hdng;
  logic        frwrd_opn, lft_opn, rght_opn;
  logic        mv_cmplt, moving, en_fusion;
  logic [10:0] frwrd_spd;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];

  maze_navigate #(.FAST_SIM(1'b1), .MAX_SPD(11'h2A0)) dut (
    .clk(clk), .rst(rst), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .at_hdng(at_hdng),
    .frwrd_opn(frwrd_opn), .lft_opn(lft_opn), .rght_opn(rght_opn),
    .mv_cmplt(mv_cmplt), .moving(moving), .en_fusion(en_fusion),
    .frwrd_spd(frwrd_spd)
  );

  always #5 clk = ~clk;

  // Advance one clock. Outputs are sampled, and inputs changed, 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push n expected speeds. Each one is the previous value plus or minus step,
  // clamped at MAX or at zero.
  task automatic push_ramp(input logic [10:0] start, input logic [10:0] step,
                           input bit up, input int n);
    int v;
    v = start;
    for (int i = 0; i < n; i++) begin
      if (up) v = (v + step > MAX) ? MAX : v + step;
      else    v = (v < step) ? 0 : v - step;
      exp_q.push_back(v[10:0]);
    end
  endtask

  // Pop and compare one expected speed per clock, while the move is still in progress.
  task automatic drain(input string name);
    logic [10:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (frwrd_spd !== e || en_fusion !== (e > HALF) || moving !== 1'b1 || mv_cmplt !== 1'b0) begin
        errors++;
        $display("FAIL %s: spd=%h fus=%b mov=%b cmplt=%b, expected spd=%h fus=%b mov=1 cmplt=0",
                 name, frwrd_spd, en_fusion, moving, mv_cmplt, e, e > HALF);
      end
    end
  endtask

  // Check the first cycle back in IDLE: a single mv_cmplt pulse at zero speed.
  task automatic expect_done(input string name);
    checks++;
    if (mv_cmplt !== 1'b1 || moving !== 1'b0 || frwrd_spd !== 11'h000) begin
      errors++;
      $display("FAIL %s done: cmplt=%b mov=%b spd=%h, expected 1 0 000", name, mv_cmplt, moving, frwrd_spd);
    end
    tick();
    checks++;
    if (mv_cmplt !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse width: cmplt=%b, expected 0", name, mv_cmplt);
    end
  endtask

  // Start a move and ramp up to the MAX_SPD ceiling. A strt_hdng strobe during ACCEL
  // must be ignored.
  task automatic accel_to_max(input string name);
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    checks++;
    if (moving !== 1'b1 || frwrd_spd !== 11'h000) begin
      errors++;
      $display("FAIL %s entry: mov=%b spd=%h, expected 1 000", name, moving, frwrd_spd);
    end
    push_ramp(11'h000, INC, 1'b1, 5);
    drain(name);
    strt_hdng = 1'b1;
    push_ramp(11'h078, INC, 1'b1, 1);
    drain(name);
    strt_hdng = 1'b0;
    push_ramp(11'h090, INC, 1'b1, 25);
    drain(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (frwrd_spd !== 11'h000 || moving !== 1'b0 || mv_cmplt !== 1'b0 || en_fusion !== 1'b0) begin
      errors++;
      $display("FAIL reset state: spd=%h mov=%b cmplt=%b fus=%b, expected 000 0 0 0",
               frwrd_spd, moving, mv_cmplt, en_fusion);
    end
    // Abort a move at 0x0C0 with a 2-cycle reset.
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    push_ramp(11'h000, INC, 1'b1, 8);
    drain("reset ramp");
    checks++;
    if (frwrd_spd !== 11'h0C0) begin
      errors++;
      $display("FAIL reset prelude: spd=%h, expected 0c0", frwrd_spd);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (frwrd_spd !== 11'h000 || moving !== 1'b0 || mv_cmplt !== 1'b0) begin
      errors++;
      $display("FAIL reset abort: spd=%h mov=%b cmplt=%b, expected 000 0 0", frwrd_spd, moving, mv_cmplt);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (mv_cmplt !== 1'b0 || moving !== 1'b0) begin
        errors++;
        $display("FAIL reset no pulse: cmplt=%b mov=%b, expected 0 0", mv_cmplt, moving);
      end
    end
  endtask

  task automatic test_heading();
    at_hdng = 1'b1;  // raised in the strobe cycle, which must not count
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    at_hdng = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (moving !== 1'b1 || frwrd_spd !== 11'h000 || mv_cmplt !== 1'b0) begin
        errors++;
        $display("FAIL heading wait: mov=%b spd=%h cmplt=%b, expected 1 000 0", moving, frwrd_spd, mv_cmplt);
      end
      if (i < 9) tick();
    end
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    expect_done("heading");
  endtask

  task automatic test_accel_side_stop();
    lft_opn = 1'b0;
    rght_opn = 1'b0;
    accel_to_max("accel");
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (frwrd_spd !== MAX || en_fusion !== 1'b1) begin
        errors++;
        $display("FAIL accel hold: spd=%h fus=%b, expected 2a0 1", frwrd_spd, en_fusion);
      end
    end
    // A right edge without stp_rght must be ignored.
    rght_opn = 1'b1;
    push_ramp(MAX, INC, 1'b1, 2);
    drain("right ignored");
    stp_lft = 1'b1;
    lft_opn = 1'b1;
    push_ramp(MAX, INC, 1'b1, 1);
    drain("left edge");
    push_ramp(MAX, INC, 1'b0, 28);
    drain("side decel");
    tick();
    stp_lft = 1'b0;
    expect_done("side stop");
  endtask

  task automatic test_wall_stop();
    accel_to_max("wall accel");
    frwrd_opn = 1'b0;
    push_ramp(MAX, INC, 1'b1, 1);
    drain("wall entry");
    push_ramp(MAX, INC * 4, 1'b0, 7);
    drain("wall decel");
    tick();
    frwrd_opn = 1'b1;
    expect_done("wall stop");
    // Wall appears in the middle of a side-stop DECEL.
    rght_opn = 1'b0;
    accel_to_max("wall2 accel");
    stp_rght = 1'b1;
    rght_opn = 1'b1;
    push_ramp(MAX, INC, 1'b1, 1);
    drain("right edge");
    push_ramp(MAX, INC, 1'b0, 3);
    drain("decel before wall");
    frwrd_opn = 1'b0;
    push_ramp(11'h258, INC, 1'b0, 1);
    drain("decel to fast");
    push_ramp(11'h240, INC * 4, 1'b0, 6);
    drain("fast from decel");
    tick();
    frwrd_opn = 1'b1;
    stp_rght = 1'b0;
    expect_done("wall from decel");
  endtask

  task automatic test_back_to_back();
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    checks++;
    if (mv_cmplt !== 1'b1) begin
      errors++;
      $display("FAIL b2b pulse: cmplt=%b, expected 1", mv_cmplt);
    end
    strt_mv = 1'b1;  // issued in the mv_cmplt cycle
    tick();
    strt_mv = 1'b0;
    checks++;
    if (moving !== 1'b1 || mv_cmplt !== 1'b0 || frwrd_spd !== 11'h000) begin
      errors++;
      $display("FAIL b2b accept: mov=%b cmplt=%b spd=%h, expected 1 0 000", moving, mv_cmplt, frwrd_spd);
    end
    push_ramp(11'h000, INC, 1'b1, 1);
    drain("b2b first step");
    frwrd_opn = 1'b0;  // fast decel from a low speed clamps at zero
    push_ramp(11'h018, INC, 1'b1, 1);
    push_ramp(11'h030, INC * 4, 1'b0, 1);
    drain("b2b clamp");
    tick();
    frwrd_opn = 1'b1;
    expect_done("b2b clamp");
    // Both strobes in the same cycle: the heading change wins.
    strt_hdng = 1'b1;
    strt_mv = 1'b1;
    tick();
    strt_hdng = 1'b0;
    strt_mv = 1'b0;
    tick();
    checks++;
    if (moving !== 1'b1 || frwrd_spd !== 11'h000) begin
      errors++;
      $display("FAIL both strobes: mov=%b spd=%h, expected 1 000 (HDNG)", moving, frwrd_spd);
    end
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    expect_done("both strobes");
  endtask

  initial begin
    rst = 1'b1; strt_hdng = 1'b0; strt_mv = 1'b0; stp_lft = 1'b0; stp_rght = 1'b0;
    at_hdng = 1'b0; frwrd_opn = 1'b1; lft_opn = 1'b1; rght_opn = 1'b1;
    test_reset();
    test_heading();
    test_accel_side_stop();
    test_wall_stop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
